// File: rtl/bnn_pkg.sv
// bnn_pkg: state-bus codes shared with the layer engines, default sizes, sequencer FSM encoding.
// Contents: BUS_* codes (000-101), DEF_N_PIXELS/DEF_LOAD_WIDTH/DEF_CLASS_W, fsm_e, bus_code().
package bnn_pkg;
   localparam logic [2:0] BUS_IDLE   = 3'b000;
   localparam logic [2:0] BUS_LOAD   = 3'b001;
   localparam logic [2:0] BUS_L1     = 3'b010;
   localparam logic [2:0] BUS_L2     = 3'b011;
   localparam logic [2:0] BUS_L3     = 3'b100;
   localparam logic [2:0] BUS_RESULT = 3'b101;
   localparam int DEF_N_PIXELS   = 784;
   localparam int DEF_LOAD_WIDTH = 8;
   localparam int DEF_CLASS_W    = 4;
   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_LOAD, S_L1, S_L2, S_L3, S_RESULT} fsm_e;
   // CLEAR shares the IDLE code so the layers see nothing until LOAD starts.
   function automatic logic [2:0] bus_code(input fsm_e s);
      return s == S_LOAD ? BUS_LOAD : s == S_L1 ? BUS_L1 : s == S_L2 ? BUS_L2 :
             s == S_L3 ? BUS_L3 : s == S_RESULT ? BUS_RESULT : BUS_IDLE;
   endfunction
endpackage

// File: rtl/bnn_sequencer_if.sv
// bnn_sequencer_if: pixel-beat load stream into the sequencer.
// Signals: load_valid/load_data from the image source, load_ready back; master = source, slave = sequencer.
interface bnn_sequencer_if #(parameter int LOAD_WIDTH = bnn_pkg::DEF_LOAD_WIDTH);
   logic                  load_valid;
   logic [LOAD_WIDTH-1:0] load_data;
   logic                  load_ready;
   modport master (output load_valid, load_data, input load_ready);
   modport slave (input load_valid, load_data, output load_ready);
endinterface

// File: rtl/bnn_watchdog.sv
// bnn_watchdog: counts cycles spent in one layer state and flags the last permitted cycle.
// Ports: clk, rst_n (async, active-low); clr restarts the count; en counts one cycle;
// expired is high during the TIMEOUT_CYCLES-th cycle since the last clear.
module bnn_watchdog import bnn_pkg::*; #(parameter int TIMEOUT_CYCLES = 65535) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);
   localparam int W = $clog2(TIMEOUT_CYCLES + 1);
   logic [W-1:0] cnt_q, cnt_d;
   assign expired = cnt_q >= W'(TIMEOUT_CYCLES - 1);
   always_comb cnt_d = clr ? '0 : (en && !expired) ? cnt_q + 1'b1 : cnt_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt_q <= '0;
      else cnt_q <= cnt_d;
endmodule

// File: rtl/bnn_sequencer.sv
// bnn_sequencer: loads a binary image beat by beat, then steps the layer engines via the state bus.
// Ports: clk, rst_n (async, active-low), start, ld (load stream slave), pixels, state, layer_clr_n,
// l1/l2/l3_done, class_in, result, result_valid, busy, error; perf_cycles when BNN_SEQ_PERF_EN is defined.
module bnn_sequencer import bnn_pkg::*; #(
   parameter int N_PIXELS       = DEF_N_PIXELS,
   parameter int LOAD_WIDTH     = DEF_LOAD_WIDTH,
   parameter int TIMEOUT_CYCLES = 65535,
   parameter int CLASS_W        = DEF_CLASS_W
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   bnn_sequencer_if.slave      ld,
   output logic [N_PIXELS-1:0] pixels,
   output logic [2:0]          state,
   output logic                layer_clr_n,
   input  logic                l1_done,
   input  logic                l2_done,
   input  logic                l3_done,
   input  logic [CLASS_W-1:0]  class_in,
   output logic [CLASS_W-1:0]  result,
   output logic                result_valid,
   output logic                busy,
   output logic                error
`ifdef BNN_SEQ_PERF_EN
   ,output logic [31:0]        perf_cycles
`endif
);
   localparam int N_BEATS = N_PIXELS / LOAD_WIDTH;
   localparam int BW = $clog2(N_BEATS + 1);
   fsm_e fsm_q, fsm_d;
   logic [BW-1:0] beat_q, beat_d;
   logic [N_PIXELS-1:0] pix_q, pix_d;
   logic [CLASS_W-1:0] res_q, res_d;
   logic [2:0] bus_q, bus_d;
   logic rv_q, rv_d, err_q, err_d, ready_q, ready_d, busy_q, busy_d, clr_n_q, clr_n_d;
   logic expired, in_layer, accept;
   assign in_layer = fsm_q inside {S_L1, S_L2, S_L3};
   assign accept = fsm_q == S_IDLE && start;
   always_comb begin
      fsm_d = fsm_q;
      beat_d = beat_q;
      pix_d = pix_q;
      res_d = res_q;
      rv_d = rv_q;
      err_d = err_q;
      case (fsm_q)
         S_IDLE: if (start) begin
            fsm_d = S_CLEAR;
            rv_d = 1'b0;
            err_d = 1'b0;
         end
         S_CLEAR: begin
            fsm_d = S_LOAD;
            pix_d = '0;
            beat_d = '0;
         end
         S_LOAD: if (ld.load_valid && ready_q) begin
            pix_d[beat_q*LOAD_WIDTH +: LOAD_WIDTH] = ld.load_data;
            beat_d = beat_q + 1'b1;
            fsm_d = beat_q == BW'(N_BEATS - 1) ? S_L1 : S_LOAD;
         end
         // A done flag wins over expiry on the last permitted cycle.
         S_L1: fsm_d = l1_done ? S_L2 : expired ? S_IDLE : S_L1;
         S_L2: fsm_d = l2_done ? S_L3 : expired ? S_IDLE : S_L2;
         S_L3: fsm_d = l3_done ? S_RESULT : expired ? S_IDLE : S_L3;
         S_RESULT: begin
            fsm_d = S_IDLE;
            res_d = class_in;
            rv_d = 1'b1;
         end
         default: fsm_d = S_IDLE;
      endcase
      err_d = err_d | (in_layer && fsm_d == S_IDLE);
      // Outputs are registered from the next state so they line up with the FSM.
      bus_d = bus_code(fsm_d);
      ready_d = fsm_d == S_LOAD;
      busy_d = fsm_d != S_IDLE;
      clr_n_d = fsm_d != S_CLEAR;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         fsm_q <= S_IDLE;
         beat_q <= '0;
         pix_q <= '0;
         res_q <= '0;
         bus_q <= BUS_IDLE;
         rv_q <= 1'b0;
         err_q <= 1'b0;
         ready_q <= 1'b0;
         busy_q <= 1'b0;
         clr_n_q <= 1'b1;
      end else begin
         fsm_q <= fsm_d;
         beat_q <= beat_d;
         pix_q <= pix_d;
         res_q <= res_d;
         bus_q <= bus_d;
         rv_q <= rv_d;
         err_q <= err_d;
         ready_q <= ready_d;
         busy_q <= busy_d;
         clr_n_q <= clr_n_d;
      end
   bnn_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
      .clk(clk), .rst_n(rst_n), .clr(fsm_d != fsm_q), .en(in_layer), .expired(expired)
   );
`ifdef BNN_SEQ_PERF_EN
   logic [31:0] perf_q, perf_d;
   // busy_q drops on the edge result_valid rises or a timeout lands, which freezes the count.
   always_comb perf_d = accept ? '0 : (busy_q && perf_q != '1) ? perf_q + 32'd1 : perf_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) perf_q <= '0;
      else perf_q <= perf_d;
   assign perf_cycles = perf_q;
`else
   logic unused_accept;
   assign unused_accept = accept;
`endif
   assign ld.load_ready = ready_q;
   assign pixels = pix_q;
   assign state = bus_q;
   assign layer_clr_n = clr_n_q;
   assign result = res_q;
   assign result_valid = rv_q;
   assign busy = busy_q;
   assign error = err_q;
endmodule

// File: tb/tb_bnn_sequencer.sv
// tb_bnn_sequencer: randomized self-checking bench against a cycle-timeline model of the sequencer.
module tb_bnn_sequencer;
   localparam int NP = 784, LW = 8, NB = NP / LW, TO = 7000, CW = 4;
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic l1_done = 1'b0, l2_done = 1'b0, l3_done = 1'b0;
   logic [CW-1:0] class_in = '0, result;
   logic [NP-1:0] pixels;
   logic [2:0] state;
   logic layer_clr_n, result_valid, busy, error;
   int cyc = 0, n_chk = 0, n_pass = 0;
   logic prev_rv;
   logic [CW-1:0] prev_res;
   logic [31:0] prev_perf;
   bnn_sequencer_if #(.LOAD_WIDTH(LW)) lif ();
`ifdef BNN_SEQ_PERF_EN
   logic [31:0] perf_cycles;
`endif
   bnn_sequencer #(.N_PIXELS(NP), .LOAD_WIDTH(LW), .TIMEOUT_CYCLES(TO), .CLASS_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .ld(lif), .pixels(pixels), .state(state),
      .layer_clr_n(layer_clr_n), .l1_done(l1_done), .l2_done(l2_done), .l3_done(l3_done),
      .class_in(class_in), .result(result), .result_valid(result_valid), .busy(busy), .error(error)
`ifdef BNN_SEQ_PERF_EN
      ,.perf_cycles(perf_cycles)
`endif
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [NP-1:0] got, input logic [NP-1:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Model: the sequencer's timeline is fixed by the cycle of acceptance (acc), the cycle of
   // the last accepted beat (e) and the layer latencies, so every expected bus value is a
   // piecewise function of the cycle number.
   task automatic run_inf(input int d1, input int d2, input int d3, input logic [CW-1:0] cls,
                          input bit stalls, input bit to, input int rst_at);
      int acc, e, nacc, rel, fin, dsum, bad_bus, bad_lr, clr_lo;
      logic [2:0] eb;
      logic lr_exp, v;
      logic [NP-1:0] exp_pix;
      bit done, aborted;
      @(negedge clk);
      check("idle_rv_hold", NP'(result_valid), NP'(prev_rv));
      check("idle_res_hold", NP'(result), NP'(prev_res));
`ifdef BNN_SEQ_PERF_EN
      check("idle_perf_hold", NP'(perf_cycles), NP'(prev_perf));
`endif
      start = 1'b1;
      acc = cyc + 1;
      e = -1; nacc = 0; bad_bus = 0; bad_lr = 0; clr_lo = 0;
      exp_pix = '0; done = 0; aborted = 0;
      dsum = d1 + d2 + d3;
      fin = to ? d1 + TO + 1 : dsum + 2;
      while (!done) begin
         @(negedge clk);
         rel = e < 0 ? 0 : cyc - e;
         eb = cyc == acc ? 3'b000 : e < 0 ? 3'b001 : rel <= d1 ? 3'b010 :
              to ? (rel <= d1 + TO ? 3'b011 : 3'b000) :
              rel <= d1 + d2 ? 3'b011 : rel <= dsum ? 3'b100 : rel == dsum + 1 ? 3'b101 : 3'b000;
         lr_exp = cyc != acc && e < 0;
         if (state !== eb) bad_bus++;
         if (lif.load_ready !== lr_exp) bad_lr++;
         if (layer_clr_n === 1'b0) clr_lo++;
         if (cyc == acc) begin
            check("acc_rv_cleared", NP'(result_valid), NP'(1'b0));
            check("acc_err_cleared", NP'(error), NP'(1'b0));
            check("acc_busy", NP'(busy), NP'(1'b1));
            check("acc_res_kept", NP'(result), NP'(prev_res));
`ifdef BNN_SEQ_PERF_EN
            check("acc_perf_zero", NP'(perf_cycles), NP'(0));
`endif
            l1_done = 1'b0; l2_done = 1'b0; l3_done = 1'b0;
         end
         if (rst_at > 0 && rel == rst_at) begin
            #2 rst_n = 1'b0;
            #1;
            check("rst_state", NP'(state), NP'(3'b000));
            check("rst_busy", NP'(busy), NP'(1'b0));
            check("rst_rv", NP'(result_valid), NP'(1'b0));
            check("rst_err", NP'(error), NP'(1'b0));
            check("rst_clr_n", NP'(layer_clr_n), NP'(1'b1));
            check("rst_ready", NP'(lif.load_ready), NP'(1'b0));
            check("rst_pixels", pixels, '0);
            check("rst_result", NP'(result), NP'(0));
`ifdef BNN_SEQ_PERF_EN
            check("rst_perf", NP'(perf_cycles), NP'(0));
`endif
            prev_rv = 1'b0; prev_res = '0; prev_perf = '0;
            done = 1; aborted = 1;
         end else begin
            if (!to && rel == fin - 1 && e >= 0) check("rv_low_in_result", NP'(result_valid), NP'(1'b0));
            if (rel == fin && e >= 0) begin
               check("fin_state", NP'(state), NP'(3'b000));
               check("fin_busy", NP'(busy), NP'(1'b0));
               check("fin_rv", NP'(result_valid), NP'(!to));
               check("fin_err", NP'(error), NP'(to));
               if (!to) check("fin_result", NP'(result), NP'(cls));
               else check("fin_result_old", NP'(result), NP'(prev_res));
               check("fin_pixels", pixels, exp_pix);
`ifdef BNN_SEQ_PERF_EN
               check("fin_perf", NP'(perf_cycles), NP'(cyc - acc));
               prev_perf = 32'(cyc - acc);
`endif
               prev_rv = !to;
               if (!to) prev_res = cls;
               done = 1;
            end
            start = stalls && lr_exp && $urandom_range(0, 7) == 0;
            v = stalls ? $urandom_range(0, 3) != 0 : lr_exp;
            lif.load_valid = v;
            lif.load_data = stalls ? LW'($urandom) : 8'hA5;
            if (v && lr_exp) begin
               exp_pix[nacc*LW +: LW] = lif.load_data;
               nacc++;
               if (nacc == NB) e = cyc;
            end
            class_in = (e >= 0 && rel == dsum + 1) ? cls : CW'($urandom);
            if (e >= 0 && rel > 0) begin
               if (rel == d1) l1_done = 1'b1;
               if (!to && rel == d1 + d2) l2_done = 1'b1;
               if (!to && rel == dsum) l3_done = 1'b1;
            end
         end
      end
      check("bus_trace_errs", NP'(bad_bus), NP'(0));
      check("load_ready_errs", NP'(bad_lr), NP'(0));
      check("clr_low_cycles", NP'(clr_lo), NP'(1));
      start = 1'b0;
      lif.load_valid = 1'b0;
      if (aborted) begin
         l1_done = 1'b0; l2_done = 1'b0; l3_done = 1'b0;
         @(negedge clk);
         rst_n = 1'b1;
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      lif.load_valid = 1'b0;
      lif.load_data = '0;
      prev_rv = 1'b0; prev_res = '0; prev_perf = '0;
      repeat (3) @(negedge clk);
      check("reset_state", NP'(state), NP'(3'b000));
      check("reset_pixels", pixels, '0);
      check("reset_result", NP'(result), NP'(0));
      check("reset_rv", NP'(result_valid), NP'(1'b0));
      check("reset_busy", NP'(busy), NP'(1'b0));
      check("reset_err", NP'(error), NP'(1'b0));
      check("reset_ready", NP'(lif.load_ready), NP'(1'b0));
      check("reset_clr_n", NP'(layer_clr_n), NP'(1'b1));
      rst_n = 1'b1;
      run_inf(6273, 100, 50, 4'd7, 0, 0, 0);
      for (int i = 0; i < 3; i++)
         run_inf($urandom_range(1, 40), $urandom_range(1, 40), $urandom_range(1, 40),
                 CW'($urandom), 1, 0, 0);
      run_inf(20, 1, 1, 4'd3, 1, 1, 0);
      run_inf(3, TO, 2, 4'd9, 1, 0, 0);
      run_inf(10, 50, 10, 4'd4, 1, 0, 15);
      run_inf(4, 5, 6, 4'd12, 1, 0, 0);
      run_inf(1, 1, 1, 4'd5, 0, 0, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
